// File: rtl/multi_freq_divider_pkg.sv
// Shared types and defaults for the multi-channel frequency divider.
// Channel output is either a one-cycle terminal pulse or a 50% square wave.
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

package multi_freq_divider_pkg;

  typedef enum logic {
    FD_PULSE  = 1'b0,
    FD_SQUARE = 1'b1
  } freq_div_mode_e;

  localparam int FD_CHANNELS = 4;

endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: tc/out are combinational from registered cnt/ldiv/sq (zero latency).
// No backpressure: en is a count event and is never stalled.
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

module freq_div_channel
  import multi_freq_divider_pkg::*;
#(
  parameter int DIV_BITS = `BYTE_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sync,
  input  logic                en,
  input  logic [DIV_BITS-1:0] div,
  input  logic                mode,
  output logic                out,
  output logic                tc
);

  localparam logic [DIV_BITS-1:0] ONE = DIV_BITS'(1);

  logic [DIV_BITS-1:0] cnt;
  logic [DIV_BITS-1:0] ldiv;
  logic                sq;
  logic                ldiv_zero;
  logic                at_last;
  logic                load;
  freq_div_mode_e      mode_e;

  // ldiv-1 is only meaningful when ldiv is nonzero, so the zero case is masked out.
  assign ldiv_zero = (ldiv == '0);
  assign at_last   = !ldiv_zero && (cnt == ldiv - ONE);
  assign tc        = en && at_last && !sync;
  assign load      = sync || (en && ldiv_zero) || tc;

  assign mode_e = freq_div_mode_e'(mode);
  assign out    = (mode_e == FD_SQUARE) ? sq : tc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      ldiv <= '0;
      sq   <= 1'b0;
    end else begin
      if (load) begin
        ldiv <= div;
        cnt  <= '0;
      end else if (en) begin
        cnt <= cnt + ONE;
      end

      if (sync) begin
        sq <= 1'b0;
      end else if (tc) begin
        sq <= ~sq;
      end
    end
  end

endmodule

// File: rtl/multi_freq_divider.sv
// Bank of independent frequency dividers sharing one synchronous restart strobe.
// Zero-latency combinational out/tc; no backpressure, each en bit is a count event.
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

module multi_freq_divider
  import multi_freq_divider_pkg::*;
#(
  parameter int CHANNELS = FD_CHANNELS,
  parameter int DIV_BITS = `BYTE_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sync,
  input  logic [CHANNELS-1:0]          en,
  input  logic [CHANNELS*DIV_BITS-1:0] div,
  input  logic [CHANNELS-1:0]          mode,
  output logic [CHANNELS-1:0]          out,
  output logic [CHANNELS-1:0]          tc
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    freq_div_channel #(
      .DIV_BITS(DIV_BITS)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .sync (sync),
      .en   (en[i]),
      .div  (div[i*DIV_BITS +: DIV_BITS]),
      .mode (mode[i]),
      .out  (out[i]),
      .tc   (tc[i])
    );
  end

endmodule
